// File: rtl/iob_vexriscv_bus_merge_pkg.sv
// Shared width helpers for the VexRiscv native bus merge.
// Packing: request {valid, addr, wdata, wstrb}, response {rdata, ready}.
package iob_vexriscv_bus_merge_pkg;

  function automatic int req_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  function automatic int resp_width(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/iob_vexriscv_bus_merge_arb.sv
// Two-requester round-robin grant; requester A wins the first tie after reset.
// Reusable for any 2:1 merge: grants only while en_i is high.
module iob_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  logic last_b_q, last_b_d;

  assign gnt_a_o = en_i & req_a_i & (~req_b_i | last_b_q);
  assign gnt_b_o = en_i & req_b_i & (~req_a_i | ~last_b_q);

  always_comb begin
    last_b_d = last_b_q;
    if (gnt_a_o)      last_b_d = 1'b0;
    else if (gnt_b_o) last_b_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_b_q <= 1'b1;
    else        last_b_q <= last_b_d;
  end

endmodule

// File: rtl/iob_vexriscv_bus_merge.sv
// Merges VexRiscv ibus/dbus onto one memory port, one transaction outstanding.
// Optional slave-response watchdog: define IOB_BUS_MERGE_TIMEOUT_EN.
module iob_vexriscv_bus_merge
  import iob_vexriscv_bus_merge_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int REQ_W       = req_width(ADDR_W, DATA_W),
  parameter int RESP_W      = resp_width(DATA_W),
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REQ_W-1:0]  ibus_req,
  output logic [RESP_W-1:0] ibus_resp,
  input  logic [REQ_W-1:0]  dbus_req,
  output logic [RESP_W-1:0] dbus_resp,
  output logic [REQ_W-1:0]  mem_req,
  input  logic [RESP_W-1:0] mem_resp,
  output logic              busy,
  output logic              timeout_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN_D = 2'd1;
  localparam logic [1:0] ST_OWN_I = 2'd2;

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  logic [1:0]        state_q, state_d;
  logic [REQ_W-1:0]  req_q, req_d;
  logic [RESP_W-1:0] owner_resp;
  logic              arb_en, gnt_d, gnt_i, mem_rdy, expire, done;

  assign arb_en  = (state_q == ST_IDLE);
  assign busy    = (state_q != ST_IDLE);
  assign mem_rdy = mem_resp[0];

  // dbus is requester A so it takes the first tie after reset
  iob_rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst),
    .en_i    (arb_en),
    .req_a_i (dbus_req[REQ_W-1]),
    .req_b_i (ibus_req[REQ_W-1]),
    .gnt_a_o (gnt_d),
    .gnt_b_o (gnt_i)
  );

`ifdef IOB_BUS_MERGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // A real ready in the expiry cycle wins over the watchdog
  assign expire = busy && !mem_rdy && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = busy ? cnt_q + 1'b1 : '0;
    err_d = err_q | expire;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign done = busy && (mem_rdy || expire);

  always_comb begin
    owner_resp = '0;
    if (done) owner_resp = mem_rdy ? mem_resp : RESP_W'(1);
  end

  assign dbus_resp = (state_q == ST_OWN_D) ? owner_resp : '0;
  assign ibus_resp = (state_q == ST_OWN_I) ? owner_resp : '0;
  assign mem_req   = busy ? req_q : '0;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_d) begin
          state_d = ST_OWN_D;
          req_d   = dbus_req;
        end else if (gnt_i) begin
          state_d = ST_OWN_I;
          req_d   = ibus_req;
        end
      end
      ST_OWN_D, ST_OWN_I: begin
        if (done) begin
          state_d          = ST_IDLE;
          req_d[REQ_W-1]   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

endmodule

// File: tb/tb_iob_vexriscv_bus_merge.sv
// Self-checking bench for iob_vexriscv_bus_merge: per-cycle reference model plus directed literals.
module tb_iob_vexriscv_bus_merge;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
  localparam int RESP_W = DATA_W + 1;
  localparam int TO_CYC = 8;
`ifdef IOB_BUS_MERGE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [REQ_W-1:0]  ibus_req = '0, dbus_req = '0, mem_req;
  logic [RESP_W-1:0] ibus_resp, dbus_resp, mem_resp = '0;
  logic              busy, timeout_err;

  iob_vexriscv_bus_merge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REQ_W(REQ_W), .RESP_W(RESP_W), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .ibus_req(ibus_req), .ibus_resp(ibus_resp),
    .dbus_req(dbus_req), .dbus_resp(dbus_resp),
    .mem_req(mem_req), .mem_resp(mem_resp),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  string served = "";

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got '%s', expected '%s'", name, act, exp);
    end
  endtask

  // Memory: answers each request mem_lat cycles after it first appears
  bit mem_en = 1'b1;
  int mem_lat = 2;
  int wait_cnt = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : ~a;
  endfunction

  always @(posedge clk) begin
    #1;
    if (!mem_en) wait_cnt = 0;
    else begin
      mem_resp = '0;
      if (mem_req[REQ_W-1]) begin
        if (wait_cnt == mem_lat) begin
          mem_resp = {mem_data(mem_req[REQ_W-2 -: ADDR_W]), 1'b1};
          wait_cnt = 0;
        end else wait_cnt++;
      end else wait_cnt = 0;
    end
  end

  // Reference model: who owns the memory, what was granted, how long it has waited
  int               m_owner;   // 0 none, 1 dbus, 2 ibus
  logic [REQ_W-1:0] m_word;
  bit               m_last_i;
  int               m_age;
  bit               m_err;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_owner = 0; m_word = '0; m_last_i = 1'b1; m_age = 0; m_err = 1'b0;
    end else if (m_owner == 0) begin
      if (dbus_req[REQ_W-1] && (!ibus_req[REQ_W-1] || m_last_i)) begin
        m_owner = 1; m_word = dbus_req; m_last_i = 1'b0;
      end else if (ibus_req[REQ_W-1]) begin
        m_owner = 2; m_word = ibus_req; m_last_i = 1'b1;
      end
      m_age = 0;
    end else if (mem_resp[0]) begin
      m_owner = 0;
    end else if (TO_EN && m_age == TO_CYC - 1) begin
      m_owner = 0; m_err = 1'b1;
    end else begin
      m_age++;
    end
  end

  always @(negedge clk) begin
    logic [RESP_W-1:0] exp_resp;
    if (rst) begin
      exp_resp = '0;
      if (m_owner != 0) begin
        if (mem_resp[0]) exp_resp = mem_resp;
        else if (TO_EN && m_age == TO_CYC - 1) exp_resp = RESP_W'(1);
      end
      chk("mem_req",     mem_req,     (m_owner != 0) ? m_word : '0);
      chk("dbus_resp",   dbus_resp,   (m_owner == 1) ? exp_resp : '0);
      chk("ibus_resp",   ibus_resp,   (m_owner == 2) ? exp_resp : '0);
      chk("busy",        busy,        m_owner != 0);
      chk("timeout_err", timeout_err, m_err);
      if (dbus_resp[0]) served = {served, "D"};
      if (ibus_resp[0]) served = {served, "I"};
    end
  end

  task automatic txn(input bit is_i, input logic [31:0] a, input logic [31:0] w,
                     input logic [3:0] s, output logic [RESP_W-1:0] resp, output int rdy_cyc);
    bit got = 1'b0;
    resp = '0;
    rdy_cyc = -1;
    if (is_i) ibus_req = {1'b1, a, w, s};
    else      dbus_req = {1'b1, a, w, s};
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      resp = is_i ? ibus_resp : dbus_resp;
      if (resp[0]) begin
        got = 1'b1;
        rdy_cyc = cyc;
      end
    end
    @(posedge clk); #1;
    if (is_i) ibus_req = '0;
    else      dbus_req = '0;
    if (!got) chk(is_i ? "ibus_ready_timeout" : "dbus_ready_timeout", 0, 1);
  endtask

  task automatic first_mem_valid(output int t, output logic [REQ_W-1:0] word);
    t = -1;
    word = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (mem_req[REQ_W-1]) begin
        t = cyc;
        word = mem_req;
        break;
      end
    end
  endtask

  logic [RESP_W-1:0] r_d, r_i, r_a;
  logic [REQ_W-1:0]  w_seen;
  int                t_rd, t_ri, t_mv, c0;

  initial begin
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_ibus_resp", ibus_resp, 0);
    chk("rst_dbus_resp", dbus_resp, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Simultaneous requests after reset: dbus first, then alternation
    @(posedge clk); #1;
    served = "";
    fork
      begin
        txn(1'b0, 32'h200, 32'h0, 4'h0, r_d, t_rd);
        txn(1'b0, 32'h204, 32'h0, 4'h0, r_d, t_rd);
      end
      begin
        txn(1'b1, 32'h1000, 32'h0, 4'h0, r_i, t_ri);
        chk("alt_ibus_rdata", r_i, {32'hFFFF_EFFF, 1'b1});
        txn(1'b1, 32'h1004, 32'h0, 4'h0, r_i, t_ri);
      end
    join
    chk_str("alt_order", served, "DIDI");

    // Single dbus read with 2-cycle memory latency
    repeat (2) @(posedge clk); #1;
    c0 = cyc;
    served = "";
    fork
      txn(1'b0, 32'h100, 32'h0, 4'h0, r_d, t_rd);
      first_mem_valid(t_mv, w_seen);
    join
    chk("rd_mem_valid_latency", t_mv - c0, 1);
    chk("rd_mem_req_word", w_seen, {1'b1, 32'h100, 32'h0, 4'h0});
    chk("rd_dbus_resp", r_d, {32'hDEAD_BEEF, 1'b1});
    chk("rd_ready_latency", t_rd - c0, 3);
    chk_str("rd_only_dbus", served, "D");

    // dbus write: fields forwarded untouched
    @(posedge clk); #1;
    fork
      txn(1'b0, 32'h40, 32'h1234_5678, 4'h3, r_d, t_rd);
      first_mem_valid(t_mv, w_seen);
    join
    chk("wr_mem_req_word", w_seen, {1'b1, 32'h40, 32'h1234_5678, 4'h3});
    chk("wr_dbus_resp", r_d, {32'hFFFF_FFBF, 1'b1});

    // Async reset while ibus owns the port
    @(posedge clk); #1;
    mem_en = 1'b0;
    mem_resp = '0;
    ibus_req = {1'b1, 32'h2000, 32'h0, 4'h0};
    repeat (3) @(posedge clk);
    #2;
    chk("own_i_busy", busy, 1);
    chk("own_i_mem_req", mem_req, {1'b1, 32'h2000, 32'h0, 4'h0});
    rst = 1'b0;
    #1;
    chk("arst_mem_req", mem_req, 0);
    chk("arst_ibus_resp", ibus_resp, 0);
    chk("arst_dbus_resp", dbus_resp, 0);
    chk("arst_busy", busy, 0);
    ibus_req = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    mem_en = 1'b1;
    #1;
    chk("post_rst_idle", busy, 0);
    @(posedge clk); #1;
    txn(1'b1, 32'h3000, 32'h0, 4'h0, r_i, t_ri);
    chk("post_rst_ibus_resp", r_i, {32'hFFFF_CFFF, 1'b1});

    // Spurious memory ready while idle
    mem_en = 1'b0;
    @(posedge clk); #1;
    mem_resp = {32'hFFFF_FFFF, 1'b1};
    @(negedge clk);
    chk("spur_ibus_resp", ibus_resp, 0);
    chk("spur_dbus_resp", dbus_resp, 0);
    chk("spur_busy", busy, 0);
    @(posedge clk); #1;
    mem_resp = '0;
    @(negedge clk);
    chk("spur_busy_after", busy, 0);

`ifdef IOB_BUS_MERGE_TIMEOUT_EN
    // Memory never answers: watchdog releases the owner on the 8th OWN cycle
    @(posedge clk); #1;
    fork
      txn(1'b0, 32'h500, 32'h0, 4'h0, r_d, t_rd);
      first_mem_valid(t_mv, w_seen);
    join
    chk("to_ready_cycle", t_rd - t_mv, TO_CYC - 1);
    chk("to_rdata_zero", r_d, {32'h0, 1'b1});
    repeat (3) begin
      @(negedge clk);
      chk("to_err_sticky", timeout_err, 1);
    end
    mem_en = 1'b1;
    @(posedge clk); #1;
    txn(1'b1, 32'h600, 32'h0, 4'h0, r_i, t_ri);
    chk("to_after_resp", r_i, {32'hFFFF_F9FF, 1'b1});
    chk("to_err_persist", timeout_err, 1);
`else
    mem_en = 1'b1;
    @(posedge clk); #1;
    txn(1'b1, 32'h600, 32'h0, 4'h0, r_i, t_ri);
    chk("late_ibus_resp", r_i, {32'hFFFF_F9FF, 1'b1});
    chk("no_timeout_err", timeout_err, 0);
`endif

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not complete, expected completion");
    $fatal(1);
  end

endmodule
